// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg                                                            |
// | Shared packet, opcode and register constants for the tracer host     |
// | configuration path.                                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam logic [1:0]  PKT_ADDR  = 2'b00;
  localparam logic [1:0]  PKT_READ  = 2'b01;
  localparam logic [1:0]  PKT_WRITE = 2'b10;
  localparam logic [1:0]  PKT_TS    = 2'b11;

  localparam logic [1:0]  REPLY_TAG = 2'b11;
  localparam logic [22:0] TS_CLAMP  = 23'h5FFFFF;

  localparam logic [2:0]  OP_WRITE  = 3'd0;
  localparam logic [2:0]  OP_READ   = 3'd1;
  localparam logic [2:0]  OP_PING   = 3'd2;

  localparam logic [3:0]  ADDR_CTRL    = 4'd0;
  localparam logic [3:0]  ADDR_SCRATCH = 4'd1;
  localparam logic [3:0]  ADDR_STATUS  = 4'd2;
  localparam logic [3:0]  ADDR_VERSION = 4'd3;

  localparam logic [2:0]  CTRL_RESET   = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D1   = 3'd1,
    ST_D2   = 3'd2,
    ST_D3   = 3'd3,
    ST_EXEC = 3'd4
  } parse_state_t;

  // Saturating 8-bit counter step; inc may be 0, 1 or 2.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_cmd_parser                                                     |
// | Assembles 4-byte host commands from the rx byte stream, with a      |
// | silence timeout that aborts partial commands.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_cmd_parser
  import trace_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd48000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_strobe,
  output logic        o_cmd_valid,
  output logic [2:0]  o_cmd_opcode,
  output logic [3:0]  o_cmd_addr,
  output logic [20:0] o_cmd_value,
  output logic        o_byte_err
);

  parse_state_t r_state;
  parse_state_t w_state_nxt;
  logic [15:0]  r_idle_cnt;
  logic [2:0]   r_opcode;
  logic [3:0]   r_addr;
  logic [6:0]   r_b1;
  logic [6:0]   r_b2;
  logic [6:0]   r_b3;
  logic         w_sync;
  logic         w_in_data;
  logic         w_timeout;

  assign w_sync    = i_rx_strobe & i_rx_data[7];
  assign w_in_data = (r_state == ST_D1) | (r_state == ST_D2) | (r_state == ST_D3);
  assign w_timeout = w_in_data & ~i_rx_strobe & (r_idle_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A sync byte restarts from any state; a data byte outside D1-D3 is stray.
  always_comb begin
    w_state_nxt = r_state;
    o_byte_err  = 1'b0;
    if (w_sync) begin
      w_state_nxt = ST_D1;
    end else if (i_rx_strobe) begin
      case (r_state)
        ST_D1:   w_state_nxt = ST_D2;
        ST_D2:   w_state_nxt = ST_D3;
        ST_D3:   w_state_nxt = ST_EXEC;
        default: begin
          w_state_nxt = ST_IDLE;
          o_byte_err  = 1'b1;
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      o_byte_err  = 1'b1;
    end else if (r_state == ST_EXEC) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= 16'd0;
      r_opcode   <= 3'd0;
      r_addr     <= 4'd0;
      r_b1       <= 7'd0;
      r_b2       <= 7'd0;
      r_b3       <= 7'd0;
    end else begin
      if (i_rx_strobe || !w_in_data) r_idle_cnt <= 16'd0;
      else                           r_idle_cnt <= r_idle_cnt + 16'd1;

      if (w_sync) begin
        r_opcode <= i_rx_data[6:4];
        r_addr   <= i_rx_data[3:0];
      end else if (i_rx_strobe) begin
        case (r_state)
          ST_D1:   r_b1 <= i_rx_data[6:0];
          ST_D2:   r_b2 <= i_rx_data[6:0];
          ST_D3:   r_b3 <= i_rx_data[6:0];
          default: ;
        endcase
      end
    end
  end

  assign o_cmd_valid  = (r_state == ST_EXEC);
  assign o_cmd_opcode = r_opcode;
  assign o_cmd_addr   = r_addr;
  assign o_cmd_value  = {r_b1, r_b2, r_b3};

endmodule
`default_nettype wire

// File: rtl/trace_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_cfg_ctrl                                                       |
// | Host config registers and reply/trace packet arbiter for the RAM     |
// | tracer. Build option: TRACE_CFG_READBACK_EN enables the read opcode  |
// | and register readback in write replies.                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_cfg_ctrl
  import trace_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd48000,
  parameter logic [20:0] VERSION = 21'h000001
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        trace_strobe,
  input  logic [1:0]  trace_type,
  input  logic [22:0] trace_payload,
  output logic        packet_strobe,
  output logic [1:0]  packet_type,
  output logic [22:0] packet_payload,
  output logic        trace_enable,
  output logic        trace_reads,
  output logic        turbo
);

  logic        w_cmd_valid;
  logic [2:0]  w_cmd_opcode;
  logic [3:0]  w_cmd_addr;
  logic [20:0] w_cmd_value;
  logic        w_byte_err;

  logic [2:0]  r_ctrl;
  logic [20:0] r_scratch;
  logic [7:0]  r_err_count;
  logic [7:0]  r_lost_count;
  logic        r_reply_pending;
  logic [20:0] r_reply_value;

  logic [20:0] w_status;
  logic [20:0] w_rd_value;
  logic [20:0] w_reply_value;
  logic        w_op_ok;
  logic        w_exec_reply;
  logic        w_exec_bad;
  logic        w_emit;
  logic        w_overrun;
  logic [1:0]  w_err_inc;
  logic [22:0] w_trace_payload;

  trace_cmd_parser #(
    .TIMEOUT (TIMEOUT)
  ) u_parser (
    .mclk         (mclk),
    .reset        (reset),
    .i_rx_data    (rx_data),
    .i_rx_strobe  (rx_strobe),
    .o_cmd_valid  (w_cmd_valid),
    .o_cmd_opcode (w_cmd_opcode),
    .o_cmd_addr   (w_cmd_addr),
    .o_cmd_value  (w_cmd_value),
    .o_byte_err   (w_byte_err)
  );

  assign w_status = {5'd0, r_err_count, r_lost_count};

  always_comb begin
    w_rd_value = 21'd0;
    case (w_cmd_addr)
      ADDR_CTRL:    w_rd_value = {18'd0, r_ctrl};
      ADDR_SCRATCH: w_rd_value = r_scratch;
      ADDR_STATUS:  w_rd_value = w_status;
      ADDR_VERSION: w_rd_value = VERSION;
      default:      w_rd_value = 21'd0;
    endcase
  end

`ifdef TRACE_CFG_READBACK_EN
  // Write readback reflects the register contents after this edge's update.
  always_comb begin
    w_op_ok       = (w_cmd_opcode == OP_WRITE) || (w_cmd_opcode == OP_READ) ||
                    (w_cmd_opcode == OP_PING);
    w_reply_value = VERSION;
    if (w_cmd_opcode == OP_WRITE) begin
      case (w_cmd_addr)
        ADDR_CTRL:    w_reply_value = {18'd0, w_cmd_value[2:0]};
        ADDR_SCRATCH: w_reply_value = w_cmd_value;
        default:      w_reply_value = w_rd_value;
      endcase
    end else if (w_cmd_opcode == OP_READ) begin
      w_reply_value = w_rd_value;
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^w_rd_value;

  always_comb begin
    w_op_ok       = (w_cmd_opcode == OP_WRITE) || (w_cmd_opcode == OP_PING);
    w_reply_value = (w_cmd_opcode == OP_WRITE) ? w_cmd_value : VERSION;
  end
`endif

  assign w_exec_reply = w_cmd_valid & w_op_ok;
  assign w_exec_bad   = w_cmd_valid & ~w_op_ok;
  assign w_emit       = r_reply_pending & ~trace_strobe;
  // Replacing a reply in the cycle it leaves the output is not a loss.
  assign w_overrun    = w_exec_reply & r_reply_pending & ~w_emit;
  assign w_err_inc    = {1'b0, w_byte_err} + {1'b0, w_exec_bad};

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_ctrl          <= CTRL_RESET;
      r_scratch       <= 21'd0;
      r_err_count     <= 8'd0;
      r_lost_count    <= 8'd0;
      r_reply_pending <= 1'b0;
      r_reply_value   <= 21'd0;
    end else begin
      if (w_cmd_valid && (w_cmd_opcode == OP_WRITE)) begin
        case (w_cmd_addr)
          ADDR_CTRL:    r_ctrl    <= w_cmd_value[2:0];
          ADDR_SCRATCH: r_scratch <= w_cmd_value;
          default:      ;
        endcase
      end
      r_err_count  <= sat_inc(r_err_count, w_err_inc);
      r_lost_count <= sat_inc(r_lost_count, {1'b0, w_overrun});
      if (w_exec_reply) begin
        r_reply_pending <= 1'b1;
        r_reply_value   <= w_reply_value;
      end else if (w_emit) begin
        r_reply_pending <= 1'b0;
      end
    end
  end

  // Keep the 2'b11 payload tag exclusive to replies.
  assign w_trace_payload = ((trace_type == PKT_TS) && (trace_payload[22:21] == REPLY_TAG)) ?
                           TS_CLAMP : trace_payload;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      packet_strobe  <= 1'b0;
      packet_type    <= 2'b00;
      packet_payload <= 23'd0;
    end else if (trace_strobe) begin
      packet_strobe  <= 1'b1;
      packet_type    <= trace_type;
      packet_payload <= w_trace_payload;
    end else if (r_reply_pending) begin
      packet_strobe  <= 1'b1;
      packet_type    <= PKT_TS;
      packet_payload <= {REPLY_TAG, r_reply_value};
    end else begin
      packet_strobe  <= 1'b0;
    end
  end

  assign trace_enable = r_ctrl[0];
  assign trace_reads  = r_ctrl[1];
  assign turbo        = r_ctrl[2];

endmodule
`default_nettype wire

// File: tb/tb_trace_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trace_cfg_ctrl                                                    |
// | Directed scoreboard bench for trace_cfg_ctrl.                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_trace_cfg_ctrl;

  localparam logic [15:0] TO  = 16'd64;
  localparam logic [20:0] VER = 21'h000001;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_strobe = 1'b0;
  logic        trace_strobe = 1'b0;
  logic [1:0]  trace_type = 2'd0;
  logic [22:0] trace_payload = 23'd0;
  logic        packet_strobe;
  logic [1:0]  packet_type;
  logic [22:0] packet_payload;
  logic        trace_enable;
  logic        trace_reads;
  logic        turbo;

  trace_cfg_ctrl #(
    .TIMEOUT (TO),
    .VERSION (VER)
  ) dut (
    .mclk           (mclk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_strobe      (rx_strobe),
    .trace_strobe   (trace_strobe),
    .trace_type     (trace_type),
    .trace_payload  (trace_payload),
    .packet_strobe  (packet_strobe),
    .packet_type    (packet_type),
    .packet_payload (packet_payload),
    .trace_enable   (trace_enable),
    .trace_reads    (trace_reads),
    .turbo          (turbo)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [1:0]  t;
    logic [22:0] p;
  } pkt_t;

  pkt_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_err = 0;
  int          exp_lost = 0;
  logic [22:0] tr_seq = 23'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: every emitted packet must match the head of the queue.
  always @(negedge mclk) begin
    if (reset && packet_strobe) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL pkt_unexpected: observed type %h payload %h expected no packet",
               packet_type, packet_payload);
      end
      if (exp_q.size() > 0) begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("pkt_type", {30'd0, packet_type}, {30'd0, e.t});
        chk("pkt_payload", {9'd0, packet_payload}, {9'd0, e.p});
      end
    end
  end

  function automatic logic [22:0] clamp_model(input logic [1:0] t, input logic [22:0] p);
    return (t == 2'b11 && p >= 23'h600000) ? 23'h5FFFFF : p;
  endfunction

  task automatic cyc(input logic rv, input logic [7:0] rb,
                     input logic tv, input logic [1:0] tt, input logic [22:0] tp);
    rx_strobe     = rv;
    rx_data       = rb;
    trace_strobe  = tv;
    trace_type    = tt;
    trace_payload = tp;
    if (tv) exp_q.push_back({tt, clamp_model(tt, tp)});
    @(negedge mclk);
    rx_strobe    = 1'b0;
    trace_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 2'b00, 23'd0);
  endtask

  task automatic trace_only(input int n);
    repeat (n) begin
      cyc(1'b0, 8'h00, 1'b1, 2'b00, tr_seq);
      tr_seq++;
    end
  endtask

  task automatic send_cmd(input logic [31:0] bytes, input logic wt);
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b1, bytes[i*8 +: 8], wt, 2'b00, tr_seq);
      tr_seq++;
    end
  endtask

  task automatic push_reply(input logic [20:0] v);
    exp_q.push_back({2'b11, 2'b11, v});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge mclk);
    chk("rst_strobe", {31'd0, packet_strobe}, 32'd0);
    chk("rst_type", {30'd0, packet_type}, 32'd0);
    chk("rst_payload", {9'd0, packet_payload}, 32'd0);
    chk("rst_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd3);
    reset = 1'b1;

    // Trace forwarding latency and hold
    cyc(1'b0, 8'h00, 1'b1, 2'b00, 23'h012345);
    chk("fwd_strobe", {31'd0, packet_strobe}, 32'd1);
    chk("fwd_payload", {9'd0, packet_payload}, 32'h012345);
    idle(1);
    chk("idle_strobe", {31'd0, packet_strobe}, 32'd0);
    chk("idle_hold", {9'd0, packet_payload}, 32'h012345);

    // CTRL write
    push_reply(21'h5);
    send_cmd(32'h80000005, 1'b0);
    idle(1);
    chk("ctrl_wr", {29'd0, turbo, trace_reads, trace_enable}, 32'd5);
    idle(3);

    // Ping delayed behind 10 trace cycles
    send_cmd(32'hA0000000, 1'b0);
    trace_only(10);
    push_reply(VER);
    idle(1);
    chk("ping_strobe", {31'd0, packet_strobe}, 32'd1);
    chk("ping_payload", {7'd0, packet_type, packet_payload}, {7'd0, 2'b11, 2'b11, VER});
    idle(1);

    // Timestamp clamp
    cyc(1'b0, 8'h00, 1'b1, 2'b11, 23'h7FFFFF);
    chk("clamp_7fffff", {9'd0, packet_payload}, 32'h5FFFFF);
    cyc(1'b0, 8'h00, 1'b1, 2'b11, 23'h600000);
    cyc(1'b0, 8'h00, 1'b1, 2'b11, 23'h5FFFFF);
    cyc(1'b0, 8'h00, 1'b1, 2'b01, 23'h7FFFFF);
    chk("noclamp_type01", {9'd0, packet_payload}, 32'h7FFFFF);
    idle(2);

    // SCRATCH write and read
    push_reply(21'h1FFFFF);
    send_cmd(32'h817F7F7F, 1'b0);
    idle(3);
    chk("scratch", {11'd0, dut.r_scratch}, 32'h1FFFFF);
`ifdef TRACE_CFG_READBACK_EN
    push_reply(21'h1FFFFF);
`else
    exp_err++;
`endif
    send_cmd(32'h91000000, 1'b0);
    idle(3);
    chk("err_after_read", {24'd0, dut.r_err_count}, 32'(exp_err));

    // Timeout boundary: TIMEOUT-1 silent cycles keep the command alive
    cyc(1'b1, 8'h80, 1'b0, 2'b00, 23'd0);
    idle(int'(TO) - 1);
    push_reply(21'h7);
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h07, 1'b0, 2'b00, 23'd0);
    idle(3);
    chk("to_edge_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd7);
    chk("to_edge_err", {24'd0, dut.r_err_count}, 32'(exp_err));

    // TIMEOUT silent cycles abort it
    cyc(1'b1, 8'h80, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    idle(int'(TO));
    exp_err++;
    chk("timeout_err", {24'd0, dut.r_err_count}, 32'(exp_err));
    chk("timeout_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd7);
`ifdef TRACE_CFG_READBACK_EN
    push_reply({5'd0, 8'(exp_err), 8'(exp_lost)});
`else
    exp_err++;
`endif
    send_cmd(32'h92000000, 1'b0);
    idle(3);
    chk("status_err", {24'd0, dut.r_err_count}, 32'(exp_err));

    // Stray data byte in IDLE
    cyc(1'b1, 8'h05, 1'b0, 2'b00, 23'd0);
    exp_err++;
    idle(1);
    chk("stray_err", {24'd0, dut.r_err_count}, 32'(exp_err));

    // Header mid-command restarts parsing
    cyc(1'b1, 8'h81, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h7F, 1'b0, 2'b00, 23'd0);
    push_reply(21'h1);
    send_cmd(32'h80000001, 1'b0);
    idle(3);
    chk("restart_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd1);
    chk("restart_err", {24'd0, dut.r_err_count}, 32'(exp_err));

    // New EXEC on the cycle the old reply leaves: no loss
    send_cmd(32'h81000011, 1'b1);
    send_cmd(32'h81000022, 1'b1);
    push_reply(21'h11);
    push_reply(21'h22);
    idle(3);
    chk("no_overrun_lost", {24'd0, dut.r_lost_count}, 32'(exp_lost));

    // Overrun under continuous trace traffic
    send_cmd(32'h81000033, 1'b1);
    send_cmd(32'h81000044, 1'b1);
    trace_only(1);
    exp_lost++;
    push_reply(21'h44);
    idle(3);
    chk("overrun_lost", {24'd0, dut.r_lost_count}, 32'(exp_lost));
    chk("overrun_scratch", {11'd0, dut.r_scratch}, 32'h44);

    // Asynchronous reset mid-command
    push_reply(21'h4);
    send_cmd(32'h80000004, 1'b0);
    idle(3);
    chk("pre_rst_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd4);
    cyc(1'b1, 8'h80, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    #2 reset = 1'b0;
    #1;
    exp_err  = 0;
    exp_lost = 0;
    chk("arst_strobe", {31'd0, packet_strobe}, 32'd0);
    chk("arst_type", {30'd0, packet_type}, 32'd0);
    chk("arst_payload", {9'd0, packet_payload}, 32'd0);
    chk("arst_ctrl", {29'd0, turbo, trace_reads, trace_enable}, 32'd3);
    chk("arst_lost", {24'd0, dut.r_lost_count}, 32'(exp_lost));
    @(negedge mclk);
    reset = 1'b1;
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    cyc(1'b1, 8'h00, 1'b0, 2'b00, 23'd0);
    exp_err += 2;
    idle(3);
    chk("post_rst_err", {24'd0, dut.r_err_count}, 32'(exp_err));

    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
